// File: rtl/credit_pipe_rx_if.sv
// Link-side and consumer-side signals of the credit receiver, bundled for port hookup.
// The slave view belongs to the receiver; the master view belongs to the sender/consumer side.
interface credit_pipe_rx_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  credit_return;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_ready;

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output credit_return,
    output out_valid,
    output out_data
  );

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  credit_return,
    input  out_valid,
    input  out_data
  );
endinterface

// File: rtl/credit_pipe_rx.sv
// Credit-based stream receiver: buffers valid-only beats in a DEPTH-entry FIFO,
// presents valid/ready downstream and returns one credit per freed slot.
module credit_pipe_rx #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  credit_pipe_rx_if.slave            bus,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic                       overflow
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  typedef enum logic {INIT, RUN} state_t;

  state_t                state, state_d;
  logic [PW-1:0]         init_cnt, init_cnt_d;
  logic                  credit_d;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         count, pending;
  logic                  pop, push, drop, emit;

  assign bus.out_valid = (count != '0);
  assign bus.out_data  = mem[rd_ptr];
  assign occupancy     = count;

  // A full FIFO may still take a beat when the head leaves in the same cycle.
  assign pop  = bus.out_valid && bus.out_ready;
  assign push = bus.in_valid && ((count != FULL) || pop);
  assign drop = bus.in_valid && !push;
  assign emit = (state == RUN) && (pending != '0);

  always_comb begin
    state_d    = state;
    init_cnt_d = init_cnt;
    credit_d   = 1'b0;
    case (state)
      INIT: begin
        credit_d = 1'b1;
        if (init_cnt == LAST) begin
          state_d    = RUN;
          init_cnt_d = '0;
        end else begin
          init_cnt_d = init_cnt + 1'b1;
        end
      end
      RUN: credit_d = emit;
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= INIT;
      init_cnt          <= '0;
      bus.credit_return <= 1'b0;
    end else begin
      state             <= state_d;
      init_cnt          <= init_cnt_d;
      bus.credit_return <= credit_d;
    end
  end

  // Pops made during INIT accumulate here and are paid out once RUN begins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      pending  <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      pending <= pending + CW'(pop) - CW'(emit);
      if (drop) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.in_data;
  end

  pending_bounded: assert property (@(posedge clk) disable iff (rst) pending <= FULL);
endmodule

// File: tb/tb_credit_pipe_rx.sv
// Directed bench for credit_pipe_rx: expected beats go into a scoreboard queue,
// a negedge monitor checks every popped head against it.
module tb_credit_pipe_rx;
  localparam int DW    = 32;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [$clog2(DEPTH+1)-1:0] occupancy;
  logic overflow;

  credit_pipe_rx_if #(.DATA_WIDTH(DW)) bus_if ();

  credit_pipe_rx #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus_if),
    .occupancy (occupancy),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  int assertions = 0;
  int failures = 0;
  int credits_seen = 0;
  logic [DW-1:0] exp_q [$];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertions++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle: drive after the rising edge, sample at the falling edge.
  task automatic applyStimulus(input logic v, input logic [DW-1:0] d, input logic r,
                               input logic acc, output logic cr);
    @(posedge clk);
    #1;
    bus_if.in_valid  = v;
    bus_if.in_data   = d;
    bus_if.out_ready = r;
    if (v && acc) exp_q.push_back(d);
    @(negedge clk);
    cr = bus_if.credit_return;
    if (cr) credits_seen++;
  endtask

  task automatic doReset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus_if.in_valid  = 1'b0;
    bus_if.out_ready = 1'b0;
    @(posedge clk);
    #1;
    exp_q.delete();
    credits_seen = 0;
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst && bus_if.out_valid && bus_if.out_ready) begin
      if (exp_q.size() == 0) begin
        assertions++;
        failures++;
        $display("[TB] FAIL unexpected_pop: got %0h, expected no beat", bus_if.out_data);
      end else begin
        checkOutput("out_data_order", bus_if.out_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic cr;
    int sent, sc, cyc;
    bus_if.in_valid  = 1'b0;
    bus_if.in_data   = '0;
    bus_if.out_ready = 1'b0;

    // Reset state and the idle INIT credit burst.
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_out_valid", bus_if.out_valid, 0);
    checkOutput("rst_credit", bus_if.credit_return, 0);
    checkOutput("rst_occupancy", occupancy, 0);
    checkOutput("rst_overflow", overflow, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int t = 1; t <= 12; t++) begin
      applyStimulus(1'b0, '0, 1'b0, 1'b0, cr);
      checkOutput("init_credit", cr, (t <= DEPTH) ? 1 : 0);
    end
    checkOutput("init_credit_total", credits_seen, DEPTH);
    checkOutput("idle_out_valid", bus_if.out_valid, 0);
    checkOutput("idle_occupancy", occupancy, 0);

    // Credit-obeying sender, 100 counting beats, out_ready toggling.
    doReset();
    sent = 0; sc = 0; cyc = 0;
    while (sent < 100 && cyc < 2000) begin
      logic v;
      v = (sc > 0);
      applyStimulus(v, DW'(sent), (cyc % 2) == 1, 1'b1, cr);
      if (v) begin
        sent++;
        sc--;
      end
      if (cr) sc++;
      cyc++;
    end
    checkOutput("stream_all_sent", sent, 100);
    cyc = 0;
    while ((exp_q.size() != 0 || occupancy != 0) && cyc < 300) begin
      applyStimulus(1'b0, '0, 1'b1, 1'b0, cr);
      if (cr) sc++;
      cyc++;
    end
    repeat (12) begin
      applyStimulus(1'b0, '0, 1'b1, 1'b0, cr);
      if (cr) sc++;
    end
    checkOutput("stream_drained", exp_q.size(), 0);
    checkOutput("stream_credit_total", credits_seen, DEPTH + 100);
    checkOutput("stream_sender_credits", sc, DEPTH);
    checkOutput("stream_overflow", overflow, 0);

    // Fill with out_ready low, then a 9th beat that must be dropped.
    doReset();
    repeat (DEPTH) applyStimulus(1'b0, '0, 1'b0, 1'b0, cr);
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, DW'(i), 1'b0, 1'b1, cr);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, cr);
    checkOutput("full_occupancy", occupancy, DEPTH);
    checkOutput("full_out_valid", bus_if.out_valid, 1);
    checkOutput("full_out_data", bus_if.out_data, 0);
    checkOutput("full_no_overflow", overflow, 0);
    applyStimulus(1'b1, 32'h8, 1'b0, 1'b0, cr);
    for (int t = 0; t < 4; t++) begin
      applyStimulus(1'b0, '0, 1'b0, 1'b0, cr);
      checkOutput("drop_overflow_sticky", overflow, 1);
      checkOutput("drop_occupancy", occupancy, DEPTH);
      checkOutput("drop_out_data_hold", bus_if.out_data, 0);
    end

    // Full FIFO, 9th beat coincides with a pop.
    doReset();
    repeat (DEPTH) applyStimulus(1'b0, '0, 1'b0, 1'b0, cr);
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, DW'(16 + i), 1'b0, 1'b1, cr);
    applyStimulus(1'b1, 32'd24, 1'b1, 1'b1, cr);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, cr);
    checkOutput("pushpop_occupancy", occupancy, DEPTH);
    checkOutput("pushpop_overflow", overflow, 0);
    checkOutput("pushpop_credit_edge", cr, 0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, cr);
    checkOutput("pushpop_credit_pulse", cr, 1);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, cr);
    checkOutput("pushpop_credit_single", cr, 0);
    cyc = 0;
    while ((exp_q.size() != 0 || occupancy != 0) && cyc < 50) begin
      applyStimulus(1'b0, '0, 1'b1, 1'b0, cr);
      cyc++;
    end
    checkOutput("pushpop_drained", exp_q.size(), 0);

    // Beat in INIT cycle 3, popped in INIT cycle 5: one extra credit after INIT.
    doReset();
    for (int t = 1; t <= 12; t++) begin
      applyStimulus(t == 3, 32'h55, t == 5, 1'b1, cr);
      checkOutput("initpop_credit", cr, (t <= DEPTH + 1) ? 1 : 0);
    end
    checkOutput("initpop_credit_total", credits_seen, DEPTH + 1);
    checkOutput("initpop_drained", exp_q.size(), 0);

    // Mid-operation reset with occupancy 5 and two pending credits.
    doReset();
    for (int t = 1; t <= DEPTH; t++)
      applyStimulus(t <= 7, DW'(32'h100 + t), (t == 5) || (t == 6), 1'b1, cr);
    checkOutput("midrst_occupancy_before", occupancy, 5);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("midrst_out_valid", bus_if.out_valid, 0);
    checkOutput("midrst_occupancy", occupancy, 0);
    checkOutput("midrst_credit", bus_if.credit_return, 0);
    checkOutput("midrst_overflow", overflow, 0);
    bus_if.in_valid = 1'b0;
    exp_q.delete();
    @(posedge clk);
    #1;
    credits_seen = 0;
    rst = 1'b0;
    for (int t = 1; t <= 12; t++) begin
      applyStimulus(1'b0, '0, 1'b1, 1'b0, cr);
      checkOutput("midrst_credit_seq", cr, (t <= DEPTH) ? 1 : 0);
    end
    checkOutput("midrst_credit_total", credits_seen, DEPTH);
    checkOutput("midrst_no_stale", bus_if.out_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end
endmodule
